// File: rtl/data_bus_bridge_if.sv
// ----------------------------------------------------------------------------
// data_bus_bridge_if
//   Core data port as seen by the bridge: MEM-stage address, store/load
//   strobes, byte mask and store data going in; load valid and load data
//   coming back in the same cycle.
//
//   Modports
//     master : the core side (drives the request, receives the load data)
//     slave  : the bridge side (receives the request, returns the load data)
// ----------------------------------------------------------------------------
interface data_bus_bridge_if;
    logic [31:0] ip_data_addr;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        ip_data_rd;
    logic        op_data_valid;
    logic [31:0] op_data_from_dmem;

    modport master (
        output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        input  op_data_valid, op_data_from_dmem
    );

    modport slave (
        input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        output op_data_valid, op_data_from_dmem
    );
endinterface

// File: rtl/data_bus_bridge.sv
// ----------------------------------------------------------------------------
// data_bus_bridge
//   Splits core data accesses between the data RAM and a 4 KiB MMIO page.
//   The MMIO page holds a console TX FIFO (drained over valid/ready) and a
//   free-running 64-bit cycle timer. Load data is returned combinationally.
//
//   MMIO word map (offset from MMIO_BASE)
//     0x000 TXDATA    write pushes wdata[7:0] when mask[0]; reads 0
//     0x004 STATUS    [0] full [1] empty [2] overflow (sticky) [15:8] count;
//                     any write clears overflow
//     0x008 MTIME_LO  reads mtime[31:0], latches mtime[63:32] into the shadow
//     0x00C MTIME_HI  reads the shadow latched by the last MTIME_LO read
//     0x010/0x014     MTIMECMP_LO/HI when TIMER_CMP_EN is defined, else 0
//
//   Ports
//     clk            core clock
//     reset          asynchronous assert, active-low; release is expected to
//                    be synchronised to clk upstream
//     bus            core data port (slave modport of data_bus_bridge_if)
//     op_ram_*       RAM request, passthrough except wr (masked by MMIO hit)
//     ip_ram_rdata   RAM asynchronous read data
//     op_tx_valid    TX FIFO head valid
//     op_tx_data     TX FIFO head byte (0 when empty)
//     ip_tx_ready    sink accepts the head byte when op_tx_valid is high
//     op_timer_irq   (TIMER_CMP_EN only) registered mtime >= mtimecmp
//
//   Configuration macro: TIMER_CMP_EN adds MTIMECMP and op_timer_irq.
// ----------------------------------------------------------------------------
module data_bus_bridge #(
    parameter int          TX_FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE     = 32'hF000_0000
) (
    input  logic                clk,
    input  logic                reset,
    data_bus_bridge_if.slave    bus,
    output logic [31:0]         op_ram_addr,
    output logic                op_ram_wr,
    output logic [3:0]          op_ram_mask,
    output logic [31:0]         op_ram_wdata,
    input  logic [31:0]         ip_ram_rdata,
    output logic                op_tx_valid,
    output logic [7:0]          op_tx_data,
    input  logic                ip_tx_ready
`ifdef TIMER_CMP_EN
    ,
    output logic                op_timer_irq
`endif
);

    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(TX_FIFO_DEPTH);

    localparam logic [9:0] W_TXDATA   = 10'd0;
    localparam logic [9:0] W_STATUS   = 10'd1;
    localparam logic [9:0] W_MTIME_LO = 10'd2;
    localparam logic [9:0] W_MTIME_HI = 10'd3;
`ifdef TIMER_CMP_EN
    localparam logic [9:0] W_CMP_LO   = 10'd4;
    localparam logic [9:0] W_CMP_HI   = 10'd5;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       mmio_hit;
    logic [9:0] word;
    logic       mmio_wr;
    logic       push;
    logic       pop;
    logic       status_wr;
    logic       lo_read;

    assign mmio_hit  = (bus.ip_data_addr[31:12] == MMIO_BASE[31:12]);
    assign word      = bus.ip_data_addr[11:2];
    assign mmio_wr   = bus.ip_data_wr & mmio_hit;
    assign push      = mmio_wr & (word == W_TXDATA) & bus.ip_data_mask[0];
    assign status_wr = mmio_wr & (word == W_STATUS);
    assign lo_read   = bus.ip_data_rd & mmio_hit & (word == W_MTIME_LO);

    assign op_ram_addr  = bus.ip_data_addr;
    assign op_ram_wr    = bus.ip_data_wr & ~mmio_hit;
    assign op_ram_mask  = bus.ip_data_mask;
    assign op_ram_wdata = bus.ip_data_from_proc;

    // ------------------------------------------------------------------
    // TX FIFO: extra pointer bit distinguishes full from empty
    // ------------------------------------------------------------------
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] count;
    logic           full;
    logic           overflow;
    logic [7:0]     mem [TX_FIFO_DEPTH];

    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == DEPTH_CNT);
    assign op_tx_valid = (wr_ptr != rd_ptr);
    assign pop         = op_tx_valid & ip_tx_ready;
    assign op_tx_data  = op_tx_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;

    // Full is taken from registered state, so a push into a full FIFO is
    // dropped even when the sink pops in the same cycle.
    logic [63:0] mtime;
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            overflow        <= 1'b0;
            mtime           <= '0;
            mtime_hi_shadow <= '0;
        end else begin
            // NOTE: state updates use <= so every register samples the
            // pre-edge values, independent of statement order.
            mtime <= mtime + 64'd1;
            if (lo_read) begin
                mtime_hi_shadow <= mtime[63:32];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end else if (status_wr) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage carries no reset; the pointers alone define which
    // entries are live, and the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= bus.ip_data_from_proc[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Optional timer compare
    // ------------------------------------------------------------------
`ifdef TIMER_CMP_EN
    logic [63:0] mtimecmp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtimecmp     <= '1;
            op_timer_irq <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mmio_wr && (word == W_CMP_LO) && bus.ip_data_mask[b]) begin
                    mtimecmp[8*b +: 8] <= bus.ip_data_from_proc[8*b +: 8];
                end
                if (mmio_wr && (word == W_CMP_HI) && bus.ip_data_mask[b]) begin
                    mtimecmp[32 + 8*b +: 8] <= bus.ip_data_from_proc[8*b +: 8];
                end
            end
            op_timer_irq <= (mtime >= mtimecmp);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    logic [31:0] mmio_rdata;

    always_comb begin
        // NOTE: default first so no path through the case leaves mmio_rdata
        // unassigned (which would infer a latch).
        mmio_rdata = '0;
        case (word)
            W_STATUS:   mmio_rdata = {16'h0, 8'(count), 5'h0, overflow, ~op_tx_valid, full};
            W_MTIME_LO: mmio_rdata = mtime[31:0];
            W_MTIME_HI: mmio_rdata = mtime_hi_shadow;
`ifdef TIMER_CMP_EN
            W_CMP_LO:   mmio_rdata = mtimecmp[31:0];
            W_CMP_HI:   mmio_rdata = mtimecmp[63:32];
`endif
            default:    mmio_rdata = '0;
        endcase
    end

    assign bus.op_data_valid     = bus.ip_data_rd;
    assign bus.op_data_from_dmem = mmio_hit ? mmio_rdata : ip_ram_rdata;

endmodule
